// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared types and helpers for the FIFO read-side arbiter.
// The state enum, the counter widths and the rotate-priority search live here.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int SRC_W   = 3;
    localparam int MAX_SRC = 8;
    localparam int BURST_W = 4;

    // First set index of req_vec at or after start, wrapping modulo n_src.
    function automatic logic [SRC_W-1:0] next_rr(
        input logic [MAX_SRC-1:0] req_vec,
        input logic [SRC_W-1:0]   start,
        input int unsigned        n_src
    );
        logic              found;
        int unsigned       pos;
        logic [SRC_W-1:0]  idx;
        found = 1'b0;
        idx   = start;
        for (int unsigned k = 0; k < MAX_SRC; k++) begin
            pos = (int'(start) + k) % n_src;
            if (k < n_src && !found && req_vec[pos[SRC_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[SRC_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first requester at or after start.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SRC_W-1:0] start,
    output logic [SRC_W-1:0] idx,
    output logic             any
);

    logic [MAX_SRC-1:0] req_ext;

    for (genvar gi = 0; gi < MAX_SRC; gi++) begin : g_ext
        if (gi < N_SRC) begin : g_used
            assign req_ext[gi] = req[gi];
        end else begin : g_pad
            assign req_ext[gi] = 1'b0;
        end
    end

    assign idx = next_rr(req_ext, start, N_SRC);
    assign any = |req;

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin read scheduler: pops N async-FIFO read ports into one output
// register, with bounded bursts and a bubble after every pop.
module fifo_rd_arbiter
    import fifo_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                    R_CLK,
    input  logic                    R_RST,
    input  logic [N_SRC-1:0]        FIFO_EMPTY,
    input  logic [N_SRC*DATA_W-1:0] FIFO_RDATA,
    output logic [N_SRC-1:0]        FIFO_RINC,
    output logic [DATA_W-1:0]       OUT_DATA,
    output logic [SRC_W-1:0]        OUT_SRC,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    BUSY
);

    state_e               state_q, state_d;
    logic [SRC_W-1:0]     grant_q, grant_d;
    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic [SRC_W-1:0]     out_src_q, out_src_d;

    logic [N_SRC-1:0]     req;
    logic [N_SRC-1:0]     grant_onehot;
    logic [N_SRC-1:0]     other_req;
    logic                 grant_req;
    logic [SRC_W-1:0]     grant_nxt;
    logic [SRC_W-1:0]     idle_idx, gap_idx;
    logic                 idle_any, gap_any;
    logic                 slot_free;
    logic                 pop;
    logic [DATA_W-1:0]    sel_data;

    assign req = ~FIFO_EMPTY;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_grant
        assign grant_onehot[gi] = (grant_q == SRC_W'(gi));
        assign other_req[gi]    = req[gi] && !grant_onehot[gi];
    end

    assign grant_req = |(req & grant_onehot);
    assign grant_nxt = (grant_q == SRC_W'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
    assign slot_free = !out_valid_q || OUT_READY;
    assign pop       = (state_q == POP) && slot_free;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (grant_q == SRC_W'(k)) sel_data = FIFO_RDATA[k*DATA_W +: DATA_W];
        end
    end

    rr_pick #(.N_SRC(N_SRC)) u_idle_pick (
        .req   (req),
        .start (rr_ptr_q),
        .idx   (idle_idx),
        .any   (idle_any)
    );

    // Leaving a grant: everyone but the current source, starting just past it.
    rr_pick #(.N_SRC(N_SRC)) u_gap_pick (
        .req   (other_req),
        .start (grant_nxt),
        .idx   (gap_idx),
        .any   (gap_any)
    );

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        out_valid_d = out_valid_q && !OUT_READY;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        case (state_q)
            IDLE: begin
                if (idle_any) begin
                    grant_d     = idle_idx;
                    burst_cnt_d = '0;
                    state_d     = POP;
                end
            end
            POP: begin
                if (slot_free) begin
                    out_data_d  = sel_data;
                    out_src_d   = grant_q;
                    out_valid_d = 1'b1;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    state_d     = GAP;
                end
            end
            GAP: begin
                if (burst_cnt_q < BURST_W'(BURST_LEN) && grant_req) begin
                    state_d = POP;
                end else begin
                    rr_ptr_d = grant_nxt;
                    if (gap_any) begin
                        grant_d     = gap_idx;
                        burst_cnt_d = '0;
                        state_d     = POP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        FIFO_RINC = '0;
        if (pop) FIFO_RINC = grant_onehot;
        BUSY      = (state_q != IDLE);
        OUT_DATA  = out_data_q;
        OUT_SRC   = out_src_q;
        OUT_VALID = out_valid_q;
    end

endmodule
